db_multich_fsm_amisha: RTL
==========================

// Module: db_multich_fsm_amisha
// PURPOSE
//   Parametrised N-channel switch/button debouncer; successor to the single-channel debounce FSM.
//   Per channel: 2-flop input synchroniser, 4-state debounce FSM with programmable stable-tick count,
//   debounced level output, and one-cycle rise/fall edge pulses.
//   One shared free-running tick prescaler serves all channels. Sits between board switches and control logic.
// PARAMETERS
//   CH_AMISHA      4   number of independent channels (>=1)
//   N_AMISHA       19  prescaler width; tick period = 2**N_AMISHA clk cycles (>=2)
//   STABLE_AMISHA  3   consecutive ticks the input must hold before the output changes (>=1)
// PORTS
//   clk_amisha      in   1          system clock, all logic on rising edge
//   reset_amisha    in   1          synchronous, active-high reset
//   sw_amisha       in   CH_AMISHA  raw asynchronous switch inputs
//   db_amisha       out  CH_AMISHA  debounced levels
//   db_rise_amisha  out  CH_AMISHA  1-cycle pulse in the first cycle db goes 0->1
//   db_fall_amisha  out  CH_AMISHA  1-cycle pulse in the first cycle db goes 1->0
//   tick_amisha     out  1          prescaler tick (exposed for verification)
// BEHAVIOUR
//   Reset (sync, active-high): prescaler q=0, sync flops=0, all FSMs ZERO, cnt=0, db_d=0;
//     the cycle after the reset edge, db/rise/fall/tick are all 0. Reset mid-operation: same,
//     including from ONE/WAIT0; no fall pulse is generated by reset.
//   Prescaler: q (N_AMISHA bits) increments every cycle, wraps 2**N-1 -> 0.
//     tick_amisha = (q == 2**N-1), combinational from q; first tick 2**N-1 cycles after reset release.
//   Synchroniser: s1<=sw, s2<=s1 per channel; FSM sees sw_s = s2 (2-cycle input latency).
//   Per-channel FSM (states ZERO, WAIT1, ONE, WAIT0; cnt width $clog2(STABLE_AMISHA+1)):
//     ZERO : db=0; sw_s=1 -> WAIT1, cnt<=0.
//     WAIT1: db=0; sw_s=0 -> ZERO (abort); else on tick: cnt==STABLE-1 -> ONE, else cnt<=cnt+1.
//     ONE  : db=1; sw_s=0 -> WAIT0, cnt<=0.
//     WAIT0: db=1; sw_s=1 -> ONE (abort); else on tick: cnt==STABLE-1 -> ZERO, else cnt<=cnt+1.
//     Illegal state encoding -> ZERO next cycle.
//   Priority: input abort beats tick when both occur in the same cycle.
//   Ticks count only while in WAIT state; the first tick may arrive any cycle after entry, so
//     settle time after sw_s change lies in ((STABLE-1)*2**N, STABLE*2**N] cycles, plus 2 sync + 1 state cycle.
//   db_amisha decoded from registered state only (glitch-free): db = (state==ONE)|(state==WAIT0).
//   Edges: db_d<=db each cycle; rise = db & ~db_d, fall = ~db & db_d; each exactly 1 cycle wide.
//   Channels fully independent; simultaneous transitions on several channels all honoured in the same cycle.
//   Any input pulse shorter than one tick period never changes db.
// TESTING (bench params: CH=4, N=3 -> tick every 8 cycles, STABLE=3)
//   1. Reset, hold sw=4'b0000 for 100 cycles -> db=0, rise=fall=0; tick pulses every 8 cycles, first 7 cycles after reset.
//   2. sw[0] 0->1 and held -> db[0] rises on the edge after the 3rd tick seen in WAIT1 (19..27 cycles after
//      sw change); rise[0] high exactly 1 cycle; db[3:1] stay 0.
//   3. sw[1] bounce: high 12 cycles, low 2, high held -> FSM aborts to ZERO, count restarts;
//      db[1] rises only after 3 full ticks measured from the final rising edge; exactly one rise pulse.
//   4. With db[2]=1, drop sw[2] low for 5 cycles then high -> db[2] stays 1, no fall pulse; hold low
//      thereafter -> db[2] falls after 3 ticks, fall[2] 1 cycle.
//   5. sw=4'b1111 simultaneous -> all four db bits rise in the same cycle with 4 simultaneous rise pulses.
//   6. Assert reset_amisha for 1 cycle while db=4'b1111 in WAIT0 -> next cycle db=0, no fall pulses,
//      q=0; with sw still high, db returns to 1 after the normal settle time.

Source files
------------

// File: rtl/db_multich_fsm_amisha.sv
`default_nettype none
// ============================================================================
// Module      : db_multich_fsm_amisha
// Description : N-channel switch/button debouncer. Each channel has a 2-flop
//               synchroniser, a 4-state debounce FSM that needs the input to
//               stay stable for STABLE_AMISHA prescaler ticks, a glitch-free
//               debounced level and single-cycle rise/fall pulses. One shared
//               free-running prescaler supplies the tick for all channels.
// Revision    : 1.0 - initial release (multi-channel successor of the
//               single-channel debounce FSM)
// ============================================================================
module db_multich_fsm_amisha #(
    parameter int CH_AMISHA     = 4,
    parameter int N_AMISHA      = 19,
    parameter int STABLE_AMISHA = 3
) (
    input  logic                 clk_amisha,
    input  logic                 reset_amisha,
    input  logic [CH_AMISHA-1:0] sw_amisha,
    output logic [CH_AMISHA-1:0] db_amisha,
    output logic [CH_AMISHA-1:0] db_rise_amisha,
    output logic [CH_AMISHA-1:0] db_fall_amisha,
    output logic                 tick_amisha
);

    localparam int c_cnt_w = $clog2(STABLE_AMISHA + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_AMISHA - 1);

    // Debounce FSM encoding; bit 1 doubles as the debounced level
    localparam logic [1:0] c_st_zero  = 2'b00;
    localparam logic [1:0] c_st_wait1 = 2'b01;
    localparam logic [1:0] c_st_one   = 2'b10;
    localparam logic [1:0] c_st_wait0 = 2'b11;

    logic [N_AMISHA-1:0]  r_q;
    logic                 w_tick;
    logic [CH_AMISHA-1:0] r_s1;
    logic [CH_AMISHA-1:0] r_s2;
    logic [CH_AMISHA-1:0] w_db;
    logic [CH_AMISHA-1:0] r_db_d;

    // Shared free-running prescaler; wraps naturally at 2**N-1
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) r_q <= '0;
        else              r_q <= r_q + 1'b1;
    end

    // Tick is the all-ones prescaler value, one cycle in every 2**N
    assign w_tick = &r_q;

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_amisha;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < CH_AMISHA; gi++) begin : g_ch
            logic [1:0]         r_state;
            logic [1:0]         w_state_nxt;
            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_nxt;

            // Channel state and stable-tick counter registers
            always_ff @(posedge clk_amisha) begin
                if (reset_amisha) begin
                    r_state <= c_st_zero;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // Next-state logic; an input reversal always wins over a tick
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    c_st_zero: begin
                        if (r_s2[gi]) begin
                            w_state_nxt = c_st_wait1;
                            w_cnt_nxt   = '0;
                        end
                    end
                    c_st_wait1: begin
                        if (!r_s2[gi]) begin
                            w_state_nxt = c_st_zero;
                            w_cnt_nxt   = '0;
                        end else if (w_tick) begin
                            if (r_cnt == c_cnt_last) w_state_nxt = c_st_one;
                            else                     w_cnt_nxt   = r_cnt + 1'b1;
                        end
                    end
                    c_st_one: begin
                        if (!r_s2[gi]) begin
                            w_state_nxt = c_st_wait0;
                            w_cnt_nxt   = '0;
                        end
                    end
                    c_st_wait0: begin
                        if (r_s2[gi]) begin
                            w_state_nxt = c_st_one;
                            w_cnt_nxt   = '0;
                        end else if (w_tick) begin
                            if (r_cnt == c_cnt_last) w_state_nxt = c_st_zero;
                            else                     w_cnt_nxt   = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_zero;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end

            // Level decoded from registered state only, so it cannot glitch
            assign w_db[gi] = (r_state == c_st_one) | (r_state == c_st_wait0);
        end
    endgenerate

    // Delayed level copy used for edge detection
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) r_db_d <= '0;
        else              r_db_d <= w_db;
    end

    assign db_amisha      = w_db;
    assign db_rise_amisha = w_db & ~r_db_d;
    assign db_fall_amisha = ~w_db & r_db_d;
    assign tick_amisha    = w_tick;

endmodule
`default_nettype wire
